// File: rtl/mfp_serial_spi.sv
// rtl/mfp_serial_spi.sv - SPI mode-0 responder bridging the IO controller to the MFP serial FIFOs
module mfp_serial_spi #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CMD_STATUS  = 8'h01,
    parameter logic [7:0] CMD_READ    = 8'h02,
    parameter logic [7:0] CMD_WRITE   = 8'h03,
    parameter logic [7:0] CMD_SETST   = 8'h04
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_ss,
    input  logic        spi_di,
    output logic        spi_do,
    input  logic [7:0]  serial_data_out,
    input  logic        serial_data_out_available,
    output logic        serial_strobe_out,
    input  logic [63:0] serial_status_out,
    output logic [7:0]  serial_data_in,
    output logic        serial_strobe_in,
    input  logic        serial_data_in_full,
    output logic [7:0]  serial_status_in,
    output logic        rx_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_STATUS,
        S_READ,
        S_WRITE,
        S_SETST,
        S_IGNORE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, di_sync;
    logic       sck_prev;
    logic       armed;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    logic [63:0] status_snap;
    logic       setst_done;

    logic       sck_s, ss_s, di_s;
    logic       active, sck_rise, sck_fall, byte_done, read_pop;
    logic [7:0] rx_byte;

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign di_s      = di_sync[SYNC_STAGES-1];
    assign active    = (state != S_IDLE) && !ss_s;
    assign sck_rise  = sck_s && !sck_prev;
    assign sck_fall  = !sck_s && sck_prev;
    assign byte_done = active && sck_rise && (bit_cnt == 3'd7);
    assign rx_byte   = {rx_shift, di_s};
    assign read_pop  = serial_data_out_available &&
                       ((state == S_READ) || ((state == S_CMD) && (rx_byte == CMD_READ)));

    // Sync chains reset low so a select held low through reset never looks like a fresh frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync <= '0;
            ss_sync  <= '0;
            di_sync  <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            ss_sync  <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
            di_sync  <= {di_sync[SYNC_STAGES-2:0], spi_di};
            sck_prev <= sck_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (ss_s) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (armed) state_next = S_CMD;
                S_CMD: begin
                    if (byte_done) begin
                        if      (rx_byte == CMD_STATUS) state_next = S_STATUS;
                        else if (rx_byte == CMD_READ)   state_next = S_READ;
                        else if (rx_byte == CMD_WRITE)  state_next = S_WRITE;
                        else if (rx_byte == CMD_SETST)  state_next = S_SETST;
                        else                            state_next = S_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed             <= 1'b0;
            bit_cnt           <= 3'd0;
            rx_shift          <= 7'd0;
            tx_shift          <= 8'd0;
            spi_do            <= 1'b0;
            status_snap       <= 64'd0;
            setst_done        <= 1'b0;
            serial_strobe_out <= 1'b0;
            serial_strobe_in  <= 1'b0;
            serial_data_in    <= 8'd0;
            serial_status_in  <= 8'd0;
            rx_overrun        <= 1'b0;
        end else begin
            serial_strobe_out <= 1'b0;
            serial_strobe_in  <= 1'b0;
            if (ss_s) begin
                armed      <= 1'b1;
                bit_cnt    <= 3'd0;
                tx_shift   <= 8'd0;
                spi_do     <= 1'b0;
                setst_done <= 1'b0;
            end else if (active) begin
                if (sck_rise) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (byte_done) begin
                        tx_shift <= 8'd0;
                        case (state)
                            S_CMD: begin
                                if (rx_byte == CMD_STATUS) begin
                                    tx_shift    <= serial_status_out[63:56];
                                    status_snap <= {serial_status_out[55:0], 8'd0};
                                    rx_overrun  <= 1'b0;
                                end
                            end
                            // Snapshot drains MSB-first; zeros shifted in give the trailing 0x00 replies.
                            S_STATUS: begin
                                tx_shift    <= status_snap[63:56];
                                status_snap <= {status_snap[55:0], 8'd0};
                            end
                            S_WRITE: begin
                                if (!serial_data_in_full) begin
                                    serial_data_in   <= rx_byte;
                                    serial_strobe_in <= 1'b1;
                                end else begin
                                    rx_overrun <= 1'b1;
                                end
                            end
                            S_SETST: begin
                                if (!setst_done) begin
                                    serial_status_in <= rx_byte;
                                    setst_done       <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                        if (read_pop) begin
                            tx_shift          <= serial_data_out;
                            serial_strobe_out <= 1'b1;
                        end
                    end
                end else if (sck_fall) begin
                    spi_do   <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_mfp_serial_spi.sv
// tb/tb_mfp_serial_spi.sv - directed-vector bench for mfp_serial_spi
module tb_mfp_serial_spi;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_ss = 1'b1;
    logic        spi_di = 1'b0;
    logic        spi_do;
    logic [7:0]  serial_data_out;
    logic        serial_data_out_available;
    logic        serial_strobe_out;
    logic [63:0] serial_status_out = 64'd0;
    logic [7:0]  serial_data_in;
    logic        serial_strobe_in;
    logic        serial_data_in_full = 1'b0;
    logic [7:0]  serial_status_in;
    logic        rx_overrun;

    mfp_serial_spi dut (
        .clk                       (clk),
        .reset                     (reset),
        .spi_sck                   (spi_sck),
        .spi_ss                    (spi_ss),
        .spi_di                    (spi_di),
        .spi_do                    (spi_do),
        .serial_data_out           (serial_data_out),
        .serial_data_out_available (serial_data_out_available),
        .serial_strobe_out         (serial_strobe_out),
        .serial_status_out         (serial_status_out),
        .serial_data_in            (serial_data_in),
        .serial_strobe_in          (serial_strobe_in),
        .serial_data_in_full       (serial_data_in_full),
        .serial_status_in          (serial_status_in),
        .rx_overrun                (rx_overrun)
    );

    always #5 clk = ~clk;

    // Output FIFO model: initial block pushes, strobe pops.
    logic [7:0] fifo_mem [0:7];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr = 4'd0;
    assign serial_data_out_available = (rd_ptr != wr_ptr);
    assign serial_data_out           = fifo_mem[rd_ptr[2:0]];
    always @(posedge clk) if (serial_strobe_out) rd_ptr <= rd_ptr + 4'd1;

    int so_cnt = 0;
    int si_cnt = 0;
    int both_cnt = 0;
    logic [7:0] si_data[$];
    always @(negedge clk) begin
        if (serial_strobe_out) so_cnt <= so_cnt + 1;
        if (serial_strobe_in) begin
            si_cnt <= si_cnt + 1;
            si_data.push_back(serial_data_in);
        end
        if (serial_strobe_out && serial_strobe_in) both_cnt <= both_cnt + 1;
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            spi_di = tx[7-i];
            #50;
            rx = {rx[6:0], spi_do};
            spi_sck = 1'b1;
            #50;
            spi_sck = 1'b0;
        end
    endtask

    task automatic sel;
        spi_ss = 1'b0;
        #100;
    endtask

    task automatic desel;
        #50;
        spi_ss = 1'b1;
        #100;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[2:0]] = b;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    logic [7:0] b;
    int so0, si0, q0;

    initial begin
        #23 reset = 1'b0;
        #20;
        check("rst_spi_do", 64'(spi_do), 64'd0);
        check("rst_strobes", 64'({serial_strobe_out, serial_strobe_in}), 64'd0);
        check("rst_data_in", 64'(serial_data_in), 64'd0);
        check("rst_status_in", 64'(serial_status_in), 64'd0);
        check("rst_overrun", 64'(rx_overrun), 64'd0);

        // STATUS: 01 + 9 dummies
        serial_status_out = 64'h0102030405060708;
        so0 = so_cnt; si0 = si_cnt;
        sel();
        spi_xfer(8'h01, 8, b);
        check("status_cmd_reply", 64'(b), 64'h00);
        for (int k = 1; k <= 9; k++) begin
            spi_xfer(8'h00, 8, b);
            check($sformatf("status_byte%0d", k), 64'(b), (k <= 8) ? 64'(k) : 64'd0);
        end
        desel();
        check("status_no_strobes", 64'((so_cnt - so0) + (si_cnt - si0)), 64'd0);

        // READ: FIFO A5,3C
        push(8'hA5); push(8'h3C);
        so0 = so_cnt;
        sel();
        spi_xfer(8'h02, 8, b); check("read_cmd_reply", 64'(b), 64'h00);
        spi_xfer(8'h00, 8, b); check("read_b1", 64'(b), 64'hA5);
        spi_xfer(8'h00, 8, b); check("read_b2", 64'(b), 64'h3C);
        spi_xfer(8'h00, 8, b); check("read_b3_empty", 64'(b), 64'h00);
        desel();
        check("read_strobe_cnt", 64'(so_cnt - so0), 64'd2);

        // WRITE: 03,11,22
        si0 = si_cnt; q0 = si_data.size();
        sel();
        spi_xfer(8'h03, 8, b);
        spi_xfer(8'h11, 8, b);
        spi_xfer(8'h22, 8, b);
        desel();
        check("write_strobe_cnt", 64'(si_cnt - si0), 64'd2);
        if (si_data.size() >= q0 + 2) begin
            check("write_d0", 64'(si_data[q0]), 64'h11);
            check("write_d1", 64'(si_data[q0+1]), 64'h22);
        end else begin
            check("write_queue_len", 64'(si_data.size() - q0), 64'd2);
        end
        check("write_overrun", 64'(rx_overrun), 64'd0);

        // Overrun with full input FIFO, then STATUS clears it
        serial_data_in_full = 1'b1;
        si0 = si_cnt;
        sel();
        spi_xfer(8'h03, 8, b);
        spi_xfer(8'h55, 8, b);
        desel();
        check("ovr_no_strobe", 64'(si_cnt - si0), 64'd0);
        check("ovr_set", 64'(rx_overrun), 64'd1);
        serial_data_in_full = 1'b0;
        sel();
        spi_xfer(8'h01, 8, b);
        desel();
        check("ovr_cleared", 64'(rx_overrun), 64'd0);

        // Abort mid-byte, then SETST
        si0 = si_cnt;
        sel();
        spi_xfer(8'h03, 8, b);
        spi_xfer(8'hFF, 5, b);
        desel();
        check("abort_no_strobe", 64'(si_cnt - si0), 64'd0);
        sel();
        spi_xfer(8'h04, 8, b);
        spi_xfer(8'hC3, 8, b);
        spi_xfer(8'h5A, 8, b);
        desel();
        check("setst_value", 64'(serial_status_in), 64'hC3);

        // Async reset during a READ data byte
        push(8'h77); push(8'h88);
        so0 = so_cnt;
        sel();
        spi_xfer(8'h02, 8, b);
        spi_xfer(8'h00, 3, b);
        check("pre_rst_bits", 64'(b[2:0]), 64'b011);
        #22;
        reset = 1'b1;
        #1;
        check("mid_rst_spi_do", 64'(spi_do), 64'd0);
        check("mid_rst_data_in", 64'(serial_data_in), 64'd0);
        check("mid_rst_status_in", 64'(serial_status_in), 64'd0);
        check("mid_rst_strobes", 64'({serial_strobe_out, serial_strobe_in, rx_overrun}), 64'd0);
        check("mid_rst_pop_cnt", 64'(so_cnt - so0), 64'd1);
        #30 reset = 1'b0;
        #20;
        so0 = so_cnt;
        spi_xfer(8'h02, 8, b);
        spi_xfer(8'h00, 8, b);
        check("post_rst_silent_miso", 64'(b), 64'h00);
        check("post_rst_no_pop", 64'(so_cnt - so0), 64'd0);
        desel();

        // Unknown command: all zeros, no pops
        so0 = so_cnt;
        sel();
        spi_xfer(8'h7F, 8, b); check("unk_cmd_reply", 64'(b), 64'h00);
        spi_xfer(8'hFF, 8, b); check("unk_b1", 64'(b), 64'h00);
        spi_xfer(8'h02, 8, b); check("unk_b2", 64'(b), 64'h00);
        desel();
        check("unk_no_pop", 64'(so_cnt - so0), 64'd0);
        check("strobes_never_both", 64'(both_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
